// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC thermometer read-out: FSM states,
// default widths and the thermometer bubble test.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int DEF_TERM_W = 8;
    localparam int DEF_CODE_W = 4;

    // A clean thermometer code is 2^k-1, so adding one clears every set bit;
    // any surviving bit lies above the lowest zero and is a bubble.
    function automatic logic therm_bubble(input logic [31:0] term);
        return |(term & (term + 32'd1));
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Combinational thermometer decoder: lowest-zero index by default, ones-count
// correction when TDC_BUBBLE_FIX_EN is defined. Bubble flag uses the lowest-zero rule.
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int TERM_W = DEF_TERM_W,
    parameter int CODE_W = DEF_CODE_W
) (
    input  logic [TERM_W-1:0] term_s,
    output logic [CODE_W-1:0] code,
    output logic              bubble
);

    always_comb begin
        code = '0;
`ifdef TDC_BUBBLE_FIX_EN
        for (int i = 0; i < TERM_W; i++) begin
            code = code + CODE_W'(term_s[i]);
        end
`else
        code = CODE_W'(TERM_W);
        for (int i = TERM_W - 1; i >= 0; i--) begin
            if (!term_s[i]) code = CODE_W'(i);
        end
`endif
    end

    assign bubble = therm_bubble(32'(term_s));

endmodule

// File: rtl/tdc_therm_reader.sv
// TDC read-out: 2-FF synchroniser, per-sample decode, burst accumulation with
// min/max/bubble tracking and a valid/ready result handshake.
module tdc_therm_reader
    import tdc_pkg::*;
#(
    parameter int TERM_W      = DEF_TERM_W,
    parameter int CODE_W      = DEF_CODE_W,
    parameter int SAMPLE_LOG2 = 4,
    parameter int SETTLE_CYC  = 3,
    parameter int ACC_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [TERM_W-1:0] term_in,
    input  logic              arm,
    output logic              busy,
    output logic [ACC_W-1:0]  result,
    output logic [CODE_W-1:0] min_code,
    output logic [CODE_W-1:0] max_code,
    output logic              bubble_err,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam int N_SAMPLES = 1 << SAMPLE_LOG2;
    localparam int CNT_MAX   = (N_SAMPLES > SETTLE_CYC) ? N_SAMPLES : SETTLE_CYC;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [TERM_W-1:0] sync_p0, term_s;
    logic [CODE_W-1:0] code;
    logic              bubble;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              settle_last, sample_last;

    logic [ACC_W-1:0]  acc, acc_upd;
    logic [CODE_W-1:0] min_acc, max_acc, min_upd, max_upd;
    logic              bub_acc, bub_upd;

    // Synchroniser: term_in is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            term_s  <= '0;
        end else begin
            sync_p0 <= term_in;
            term_s  <= sync_p0;
        end
    end

    tdc_therm_decode #(
        .TERM_W (TERM_W),
        .CODE_W (CODE_W)
    ) u_decode (
        .term_s (term_s),
        .code   (code),
        .bubble (bubble)
    );

    assign settle_last = (cnt == CNT_W'(SETTLE_CYC - 1));
    assign sample_last = (cnt == CNT_W'(N_SAMPLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (arm && ena) state_nxt = ST_SETTLE;
            ST_SETTLE: begin
                if (!ena)             state_nxt = ST_IDLE;
                else if (settle_last) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (!ena)             state_nxt = ST_IDLE;
                else if (sample_last) state_nxt = ST_DONE;
            end
            ST_DONE:   if (result_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign acc_upd = acc + ACC_W'(code);
    assign min_upd = (code < min_acc) ? code : min_acc;
    assign max_upd = (code > max_acc) ? code : max_acc;
    assign bub_upd = bub_acc | bubble;

    // Running statistics; the visible outputs change only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            acc        <= '0;
            min_acc    <= '0;
            max_acc    <= '0;
            bub_acc    <= 1'b0;
            result     <= '0;
            min_code   <= '0;
            max_code   <= '0;
            bubble_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: cnt <= '0;
                ST_SETTLE: begin
                    cnt     <= settle_last ? '0 : cnt + CNT_W'(1);
                    acc     <= '0;
                    min_acc <= '1;
                    max_acc <= '0;
                    bub_acc <= 1'b0;
                end
                ST_SAMPLE: begin
                    cnt     <= cnt + CNT_W'(1);
                    acc     <= acc_upd;
                    min_acc <= min_upd;
                    max_acc <= max_upd;
                    bub_acc <= bub_upd;
                    if (ena && sample_last) begin
                        result     <= acc_upd;
                        min_code   <= min_upd;
                        max_code   <= max_upd;
                        bubble_err <= bub_upd;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != ST_IDLE);
    assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_tdc_therm_reader.sv
// Directed self-checking bench for tdc_therm_reader (default parameters).
module tb_tdc_therm_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] term_in = 8'h00;
    logic       arm = 1'b0;
    logic       busy;
    logic [7:0] result;
    logic [3:0] min_code, max_code;
    logic       bubble_err;
    logic       result_valid;
    logic       result_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    tdc_therm_reader #(
        .TERM_W(8), .CODE_W(4), .SAMPLE_LOG2(4), .SETTLE_CYC(3), .ACC_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .term_in      (term_in),
        .arm          (arm),
        .busy         (busy),
        .result       (result),
        .min_code     (min_code),
        .max_code     (max_code),
        .bubble_err   (bubble_err),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Pulse arm and wait for result_valid; lat = edges from the arm edge (inclusive).
    // mode 1 alternates term_in between 8'h03 and 8'h0F every cycle.
    task automatic run_burst(input int mode, output int lat);
        int count;
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        count = 1;
        #1;
        while (!result_valid && count < 60) begin
            @(negedge clk);
            arm = 1'b0;
            if (mode == 1) term_in = (count % 2 == 1) ? 8'h03 : 8'h0F;
            @(posedge clk);
            count++;
            #1;
        end
        arm = 1'b0;
        lat = count;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (result !== 8'd0 || min_code !== 4'd0 || max_code !== 4'd0 ||
            bubble_err !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: res=%0d min=%0d max=%0d bub=%b rv=%b busy=%b expected all 0",
                     result, min_code, max_code, bubble_err, result_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        result_ready = 1'b1;
    endtask

    task automatic test_static();
        int lat;
        term_in = 8'b0001_1111;
        run_burst(0, lat);
        checks++;
        if (lat !== 20) begin
            failures++;
            $display("FAIL static_latency: got %0d expected 20", lat);
        end
        checks++;
        if (result !== 8'd80 || min_code !== 4'd5 || max_code !== 4'd5 || bubble_err !== 1'b0) begin
            failures++;
            $display("FAIL static_result: res=%0d min=%0d max=%0d bub=%b expected 80 5 5 0",
                     result, min_code, max_code, bubble_err);
        end
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL static_release: rv=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_changing();
        int lat;
        term_in = 8'h03;
        run_burst(1, lat);
        checks++;
        if (lat !== 20 || result !== 8'd48 || min_code !== 4'd2 || max_code !== 4'd4 ||
            bubble_err !== 1'b0) begin
            failures++;
            $display("FAIL changing_result: lat=%0d res=%0d min=%0d max=%0d bub=%b expected 20 48 2 4 0",
                     lat, result, min_code, max_code, bubble_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bubble();
        int lat;
        logic [7:0] exp_res;
        logic [3:0] exp_code;
`ifdef TDC_BUBBLE_FIX_EN
        exp_res = 8'd64;
        exp_code = 4'd4;
`else
        exp_res = 8'd48;
        exp_code = 4'd3;
`endif
        term_in = 8'b0001_0111;
        run_burst(0, lat);
        checks++;
        if (lat !== 20 || result !== exp_res || min_code !== exp_code ||
            max_code !== exp_code || bubble_err !== 1'b1) begin
            failures++;
            $display("FAIL bubble_result: lat=%0d res=%0d min=%0d max=%0d bub=%b expected 20 %0d %0d %0d 1",
                     lat, result, min_code, max_code, bubble_err, exp_res, exp_code, exp_code);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        bit seen;
        term_in = 8'b0001_1111;
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 8'd0 || min_code !== 4'd0 || max_code !== 4'd0 ||
            bubble_err !== 1'b0 || result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: res=%0d min=%0d max=%0d bub=%b rv=%b busy=%b expected all 0",
                     result, min_code, max_code, bubble_err, result_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (result_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_result: activity=%b expected 0", seen);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit bad;
        term_in = 8'b0001_1111;
        result_ready = 1'b0;
        run_burst(0, lat);
        checks++;
        if (lat !== 20 || result !== 8'd80) begin
            failures++;
            $display("FAIL bp_result: lat=%0d res=%0d expected 20 80", lat, result);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            term_in = 8'(i * 37 + 1);
            arm = (i % 2 == 0);
            @(posedge clk); #1;
            if (result_valid !== 1'b1 || busy !== 1'b1 || result !== 8'd80 ||
                min_code !== 4'd5 || max_code !== 4'd5 || bubble_err !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL bp_hold: outputs changed under backpressure, last res=%0d rv=%b expected 80 1",
                     result, result_valid);
        end
        @(negedge clk);
        result_ready = 1'b1;
        arm = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: rv=%b busy=%b expected 0 0", result_valid, busy);
        end
        @(negedge clk);
        arm = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_arm_ignored: busy=%b expected 0", busy);
        end
        term_in = 8'b0001_1111;
    endtask

    task automatic test_abort();
        bit seen;
        term_in = 8'hFF;
        @(negedge clk);
        arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arm = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        ena = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle: busy=%b rv=%b expected 0 0", busy, result_valid);
        end
        @(negedge clk);
        ena = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || result !== 8'd80 || min_code !== 4'd5 || max_code !== 4'd5) begin
            failures++;
            $display("FAIL abort_retain: rv_seen=%b res=%0d min=%0d max=%0d expected 0 80 5 5",
                     seen, result, min_code, max_code);
        end
    endtask

    task automatic test_extremes();
        int lat;
        term_in = 8'hFF;
        run_burst(0, lat);
        checks++;
        if (lat !== 20 || result !== 8'd128 || min_code !== 4'd8 || max_code !== 4'd8 ||
            bubble_err !== 1'b0) begin
            failures++;
            $display("FAIL extreme_full: lat=%0d res=%0d min=%0d max=%0d bub=%b expected 20 128 8 8 0",
                     lat, result, min_code, max_code, bubble_err);
        end
        @(posedge clk); #1;
        term_in = 8'h00;
        run_burst(0, lat);
        checks++;
        if (lat !== 20 || result !== 8'd0 || min_code !== 4'd0 || max_code !== 4'd0 ||
            bubble_err !== 1'b0) begin
            failures++;
            $display("FAIL extreme_empty: lat=%0d res=%0d min=%0d max=%0d bub=%b expected 20 0 0 0 0",
                     lat, result, min_code, max_code, bubble_err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_static();
        test_changing();
        test_bubble();
        test_async_reset();
        test_backpressure();
        test_abort();
        test_extremes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
